alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Hardwired control sequencer: drives Datapath strobes through fetch (T0-T2) and execute (T3-T6) for ALU ops.
//  Decodes IR opcode/register fields and sequences PC/MAR/MDR/IR/Y/Z/LO/HI and one-hot GPR strobes.
//  Generalises hand-stepped per-op bench sequencing to any REG_CNT, memory wait states and mul/div HI/LO writeback.
// PARAMETERS
//  DATA_W     32  IR / datapath width
//  REG_CNT    16  number of GPRs; width of Rin/Rout one-hot buses
//  REG_IDX_W  4   width of IR register fields (Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]); opcode=IR[31:27]
//  AUTO_RUN   0   1: DONE -> T0 directly (continuous fetch); 0: DONE -> IDLE
// PORTS
//  Clock      in   1        rising-edge clock
//  Clear      in   1        synchronous active-low reset
//  Start      in   1        begin instruction cycle (sampled in IDLE only)
//  Mem_Ready  in   1        memory read complete; T1 holds while low
//  IR         in   DATA_W   instruction register contents (valid from T3)
//  PC_Out, MDR_Out, ZLO_Out, ZHI_Out          out 1  bus drive strobes
//  PC_In, MAR_In, MDR_In, IR_In, Y_In, ZLO_In, ZHI_In, LO_In, HI_In  out 1  load strobes
//  IncPC, Read out 1        PC increment / memory read
//  Rout       out  REG_CNT  one-hot GPR bus drive
//  Rin        out  REG_CNT  one-hot GPR load
//  CONTROL    out  5        ALU operation select
//  Busy       out  1        high in every state except IDLE
//  Done       out  1        one-cycle pulse, instruction retired
//  Illegal    out  1        one-cycle pulse, bad opcode or reg index >= REG_CNT
// BEHAVIOUR
//  - Moore FSM, outputs decoded from state register only; all outputs 0 in IDLE and on reset.
//  - Clear low at posedge: state<=IDLE; all strobes 0 from next cycle regardless of state (mid-op abort, no writes).
//  - States: IDLE,T0,T1,T2,T3,T4,T5,T6,DONE,ERR. At most one *_Out or Rout bit high in any cycle.
//  - IDLE: Start=1 -> T0. Start while Busy ignored.
//  - T0: PC_Out,MAR_In,IncPC,ZLO_In. -> T1.
//  - T1: ZLO_Out,PC_In,Read,MDR_In. Mem_Ready=0 -> stay T1, strobes held; Mem_Ready=1 -> T2.
//  - T2: MDR_Out,IR_In. -> T3.
//  - T3: decode IR; illegal -> ERR (no strobes in T3). Else Rout[Rb],Y_In. -> T4.
//  - T4: CONTROL=map(op),ZLO_In; binary ops add Rout[Rc]; mul/div add ZHI_In. -> T5.
//  - T5: ZLO_Out; non-mul/div: Rin[Ra] -> DONE; mul/div: LO_In -> T6.
//  - T6 (mul/div only): ZHI_Out,HI_In. -> DONE.
//  - DONE: Done=1. AUTO_RUN=1 or Start=1 -> T0, else IDLE.
//  - ERR: Illegal=1, no other strobes. -> IDLE.
//  - Opcode->CONTROL: add 00011->00011, sub 00100->00100, and 00101->00101, or 00110->00110,
//    mul 01111->01111, div 10000->10000, not 10001->01011, neg 10010->01100; all others illegal.
//  - Unary (not,neg): Rc ignored, never driven. Mul/div: Ra ignored, never written.
//  - CONTROL is 0 outside T4.
//  - Latency from Start edge: ALU op = 7 cycles to Done (T0..T5,DONE); mul/div = 8; +1 per Mem_Ready-low cycle.
// TESTING
//  1 not: IR=32'h8800_0000|Ra=5,Rb=2 -> T3 Rout[2],Y_In; T4 CONTROL=01011,ZLO_In; T5 ZLO_Out,Rin[5]; Done at cycle 7.
//  2 add Ra=1,Rb=2,Rc=3, Mem_Ready low 3 cycles in T1 -> T1 strobes held 4 cycles; Rout[3] in T4; Done at cycle 10.
//  3 mul Ra=0,Rb=4,Rc=6 -> T4 ZHI_In+ZLO_In; T5 ZLO_Out,LO_In; T6 ZHI_Out,HI_In; Rin stays 0; Done at cycle 8.
//  4 opcode 11111, and add with Rb=REG_CNT (REG_CNT=8) -> Illegal pulse after T3, no Rin bit ever set, back to IDLE.
//  5 Clear low during T4 of sub -> next cycle IDLE, all outputs 0, Rin never asserted; Start then runs cleanly.
//  6 AUTO_RUN=1, two back-to-back adds -> DONE followed directly by T0; Start held high in T2 has no effect.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Hardwired control sequencer for ALU instructions: fetch in T0-T2, execute in T3-T6.
// Moore FSM; strobes come from the state register plus the held IR fields.
module alu_op_sequencer #(
  parameter int DATA_W    = 32,
  parameter int REG_CNT   = 16,
  parameter int REG_IDX_W = 4,
  parameter int AUTO_RUN  = 0
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Start,
  input  logic               Mem_Ready,
  input  logic [DATA_W-1:0]  IR,
  output logic               PC_Out,
  output logic               MDR_Out,
  output logic               ZLO_Out,
  output logic               ZHI_Out,
  output logic               PC_In,
  output logic               MAR_In,
  output logic               MDR_In,
  output logic               IR_In,
  output logic               Y_In,
  output logic               ZLO_In,
  output logic               ZHI_In,
  output logic               LO_In,
  output logic               HI_In,
  output logic               IncPC,
  output logic               Read,
  output logic [REG_CNT-1:0] Rout,
  output logic [REG_CNT-1:0] Rin,
  output logic [4:0]         CONTROL,
  output logic               Busy,
  output logic               Done,
  output logic               Illegal
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;
  localparam logic [3:0] S_ERR  = 4'd9;

  localparam logic [REG_CNT-1:0] ONE = {{(REG_CNT-1){1'b0}}, 1'b1};

  logic [3:0]           state_q, state_d;
  logic [4:0]           opcode;
  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic [4:0]           aluCtrl;
  logic                 opLegal, isUnary, isMulDiv;
  logic                 raOk, rbOk, rcOk, illegalOp;
  logic                 unused_ir_bits;

  assign opcode         = IR[31:27];
  assign ra             = IR[26 -: REG_IDX_W];
  assign rb             = IR[22 -: REG_IDX_W];
  assign rc             = IR[18 -: REG_IDX_W];
  assign unused_ir_bits = ^IR[14:0];

  function automatic logic [REG_CNT-1:0] oneHot(input logic [REG_IDX_W-1:0] idx);
    return ONE << idx;
  endfunction

  always_comb begin
    aluCtrl  = 5'b00000;
    opLegal  = 1'b1;
    isUnary  = 1'b0;
    isMulDiv = 1'b0;
    case (opcode)
      5'b00011: aluCtrl = 5'b00011;
      5'b00100: aluCtrl = 5'b00100;
      5'b00101: aluCtrl = 5'b00101;
      5'b00110: aluCtrl = 5'b00110;
      5'b01111: begin aluCtrl = 5'b01111; isMulDiv = 1'b1; end
      5'b10000: begin aluCtrl = 5'b10000; isMulDiv = 1'b1; end
      5'b10001: begin aluCtrl = 5'b01011; isUnary  = 1'b1; end
      5'b10010: begin aluCtrl = 5'b01100; isUnary  = 1'b1; end
      default:  opLegal = 1'b0;
    endcase
  end

  // Only the register fields an opcode actually uses may make it illegal.
  assign raOk      = 32'(ra) < REG_CNT;
  assign rbOk      = 32'(rb) < REG_CNT;
  assign rcOk      = 32'(rc) < REG_CNT;
  assign illegalOp = !opLegal || !rbOk || (!isMulDiv && !raOk) || (!isUnary && !rcOk);

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = Start ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = Mem_Ready ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = illegalOp ? S_ERR : S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = isMulDiv ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = ((AUTO_RUN != 0) || Start) ? S_T0 : S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    PC_Out  = 1'b0; MDR_Out = 1'b0; ZLO_Out = 1'b0; ZHI_Out = 1'b0;
    PC_In   = 1'b0; MAR_In  = 1'b0; MDR_In  = 1'b0; IR_In   = 1'b0;
    Y_In    = 1'b0; ZLO_In  = 1'b0; ZHI_In  = 1'b0; LO_In   = 1'b0;
    HI_In   = 1'b0; IncPC   = 1'b0; Read    = 1'b0;
    Rout    = '0;   Rin     = '0;   CONTROL = 5'b00000;
    Done    = 1'b0; Illegal = 1'b0;
    Busy    = (state_q != S_IDLE);
    case (state_q)
      S_T0: begin PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; ZLO_In = 1'b1; end
      S_T1: begin ZLO_Out = 1'b1; PC_In = 1'b1; Read = 1'b1; MDR_In = 1'b1; end
      S_T2: begin MDR_Out = 1'b1; IR_In = 1'b1; end
      S_T3: begin
        if (!illegalOp) begin
          Rout = oneHot(rb);
          Y_In = 1'b1;
        end
      end
      S_T4: begin
        CONTROL = aluCtrl;
        ZLO_In  = 1'b1;
        if (!isUnary) Rout = oneHot(rc);
        if (isMulDiv) ZHI_In = 1'b1;
      end
      S_T5: begin
        ZLO_Out = 1'b1;
        if (isMulDiv) LO_In = 1'b1;
        else          Rin = oneHot(ra);
      end
      S_T6:   begin ZHI_Out = 1'b1; HI_In = 1'b1; end
      S_DONE: Done = 1'b1;
      S_ERR:  Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
